// File: rtl/xpe_pkg.sv
// Shared constants, state encoding and config type for the XPE layer sequencer.
package xpe_pkg;

    localparam int LUT_AW = 4;
    localparam int LUT_DW = 24;

    localparam logic [3:0] CONV     = 4'd1;
    localparam logic [3:0] FC       = 4'd2;
    localparam logic [3:0] ADD      = 4'd3;
    localparam logic [3:0] POOL     = 4'd4;
    localparam logic [3:0] AVG_POOL = 4'd5;
    localparam logic [3:0] MATRIX   = 4'd6;
    localparam logic [3:0] DOTACC   = 4'd8;

    localparam logic [1:0] NOACT   = 2'd0;
    localparam logic [1:0] RELU    = 2'd1;
    localparam logic [1:0] SIGMOID = 2'd2;
    localparam logic [1:0] TANH    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LUT_LOAD = 3'd1,
        ST_RUN      = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } xpe_state_e;

    typedef struct packed {
        logic [3:0] mode;
        logic [1:0] xpe_mode;
        logic       lut_reload;
    } xpe_cfg_t;

    // Only the table-driven activations use the LUT.
    function automatic logic act_needs_lut(input logic [1:0] act);
        return (act == SIGMOID) || (act == TANH);
    endfunction

endpackage

// File: rtl/xpe_lut_loader.sv
// Activation LUT loader: accepts LUT_DEPTH entries over a vld/rdy handshake and
// replays each one as a single registered BRAM write on the following cycle.
module xpe_lut_loader
    import xpe_pkg::*;
#(
    parameter int LUT_DEPTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load_start,
    input  logic              i_abort,
    input  logic [LUT_DW-1:0] i_lut_dat,
    input  logic              i_lut_vld,
    output logic              o_lut_rdy,
    output logic [LUT_DW-1:0] o_wdata,
    output logic [LUT_AW-1:0] o_addr,
    output logic              o_we,
    output logic              o_en,
    output logic              o_load_done
);

    logic              rdy_q, rdy_d;
    logic              we_q, we_d;
    logic [LUT_AW-1:0] cnt_q, cnt_d;
    logic [LUT_AW-1:0] addr_q, addr_d;
    logic [LUT_DW-1:0] wdata_q, wdata_d;
    logic              hs;
    logic              last_hs;

    assign hs      = rdy_q && i_lut_vld;
    assign last_hs = hs && (cnt_q == LUT_AW'(LUT_DEPTH - 1));

    always_comb begin
        rdy_d   = rdy_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        if (hs) begin
            we_d    = 1'b1;
            addr_d  = cnt_q;
            wdata_d = i_lut_dat;
            cnt_d   = cnt_q + LUT_AW'(1);
            if (last_hs) begin
                rdy_d = 1'b0;
            end
        end
        if (i_load_start) begin
            rdy_d = 1'b1;
            cnt_d = '0;
        end
        // Abort discards any write captured this cycle.
        if (i_abort) begin
            rdy_d   = 1'b0;
            cnt_d   = '0;
            we_d    = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdy_q   <= 1'b0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            rdy_q   <= rdy_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_lut_rdy   = rdy_q;
    assign o_we        = we_q;
    assign o_en        = we_q;
    assign o_addr      = addr_q;
    assign o_wdata     = wdata_q;
    assign o_load_done = last_hs && !i_abort;

endmodule

// File: rtl/xpe_ctrl.sv
// Layer-level sequencer for the XPE post-processing datapath: LUT load,
// calculation enable, beat counting, drain with timeout, done/error reporting.
module xpe_ctrl
    import xpe_pkg::*;
#(
    parameter int LUT_DEPTH     = 16,
    parameter int BEAT_W        = 16,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [3:0]        i_mode,
    input  logic [1:0]        i_xpe_mode,
    input  logic              i_lut_reload,
    input  logic [BEAT_W-1:0] i_beat_num,
    input  logic [LUT_DW-1:0] i_lut_dat,
    input  logic              i_lut_vld,
    output logic              o_lut_rdy,
    output logic [LUT_DW-1:0] o_lut_bramctl_wdata,
    output logic [LUT_AW-1:0] o_lut_bramctl_addr,
    output logic              o_lut_bramctl_we,
    output logic              o_lut_bramctl_en,
    input  logic              i_in_vld,
    input  logic              i_out_vld,
    output logic              o_calc_en,
    output logic              o_calculate_end,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);

    xpe_state_e        state_q, state_d;
    xpe_cfg_t          cfg_q, cfg_d;
    logic [BEAT_W-1:0] beat_num_q, beat_num_d;
    logic [BEAT_W-1:0] in_cnt_q, in_cnt_d;
    logic [BEAT_W-1:0] out_cnt_q, out_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              calc_en_q, calc_en_d;
    logic              calc_end_q, calc_end_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              lut_start;
    logic              lut_done;
    logic              out_beat;
    logic              unused_cfg;

    // The latched config is kept for visibility; only beat_num steers control.
    assign unused_cfg = ^cfg_q;
    assign out_beat   = i_out_vld && ((state_q == ST_RUN) || (state_q == ST_DRAIN));

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        beat_num_d = beat_num_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        idle_cnt_d = idle_cnt_q;
        err_d      = err_q;
        calc_end_d = 1'b0;
        done_d     = 1'b0;
        lut_start  = 1'b0;

        if (out_beat) begin
            if (out_cnt_q == beat_num_q) begin
                err_d = 1'b1;
            end else begin
                out_cnt_d = out_cnt_q + BEAT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    cfg_d      = '{mode: i_mode, xpe_mode: i_xpe_mode, lut_reload: i_lut_reload};
                    beat_num_d = i_beat_num;
                    in_cnt_d   = '0;
                    out_cnt_d  = '0;
                    idle_cnt_d = '0;
                    err_d      = 1'b0;
                    if (i_lut_reload && act_needs_lut(i_xpe_mode)) begin
                        state_d   = ST_LUT_LOAD;
                        lut_start = 1'b1;
                    end else if (i_beat_num == '0) begin
                        state_d    = ST_DONE;
                        calc_end_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_LUT_LOAD: begin
                if (lut_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                idle_cnt_d = '0;
                if (i_in_vld) begin
                    in_cnt_d = in_cnt_q + BEAT_W'(1);
                    if ((in_cnt_q + BEAT_W'(1)) == beat_num_q) begin
                        calc_end_d = 1'b1;
                        state_d    = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_cnt_q == beat_num_q) begin
                    state_d = ST_DONE;
                end else if (i_out_vld) begin
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    if ((idle_cnt_q + IDLE_W'(1)) == IDLE_W'(DRAIN_TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over everything, but leaves the sticky error alone.
        if (i_abort) begin
            state_d    = ST_IDLE;
            in_cnt_d   = '0;
            out_cnt_d  = '0;
            idle_cnt_d = '0;
            err_d      = err_q;
            calc_end_d = 1'b0;
            done_d     = 1'b0;
            lut_start  = 1'b0;
        end

        calc_en_d = (state_d == ST_RUN);
        // Busy stays up through the done pulse so the layer never looks idle early.
        busy_d    = (state_d != ST_IDLE) || done_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            cfg_q      <= '0;
            beat_num_q <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            idle_cnt_q <= '0;
            calc_en_q  <= 1'b0;
            calc_end_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            beat_num_q <= beat_num_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            calc_en_q  <= calc_en_d;
            calc_end_q <= calc_end_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    xpe_lut_loader #(
        .LUT_DEPTH (LUT_DEPTH)
    ) u_lut_loader (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load_start (lut_start),
        .i_abort      (i_abort),
        .i_lut_dat    (i_lut_dat),
        .i_lut_vld    (i_lut_vld),
        .o_lut_rdy    (o_lut_rdy),
        .o_wdata      (o_lut_bramctl_wdata),
        .o_addr       (o_lut_bramctl_addr),
        .o_we         (o_lut_bramctl_we),
        .o_en         (o_lut_bramctl_en),
        .o_load_done  (lut_done)
    );

    assign o_calc_en       = calc_en_q;
    assign o_calculate_end = calc_end_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_err           = err_q;

endmodule

// File: tb/tb_xpe_ctrl.sv
// Directed bench for xpe_ctrl: normal run, LUT load, zero-beat layer, drain
// timeout, abort during LUT load, output overrun and asynchronous reset.
module tb_xpe_ctrl;
    import xpe_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [3:0]  i_mode = 4'd0;
    logic [1:0]  i_xpe_mode = 2'd0;
    logic        i_lut_reload = 1'b0;
    logic [15:0] i_beat_num = 16'd0;
    logic [23:0] i_lut_dat = 24'd0;
    logic        i_lut_vld = 1'b0;
    logic        i_in_vld = 1'b0;
    logic        i_out_vld = 1'b0;
    logic        o_lut_rdy;
    logic [23:0] o_lut_bramctl_wdata;
    logic [3:0]  o_lut_bramctl_addr;
    logic        o_lut_bramctl_we;
    logic        o_lut_bramctl_en;
    logic        o_calc_en;
    logic        o_calculate_end;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 i_clk = ~i_clk;

    xpe_ctrl dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_start             (i_start),
        .i_abort             (i_abort),
        .i_mode              (i_mode),
        .i_xpe_mode          (i_xpe_mode),
        .i_lut_reload        (i_lut_reload),
        .i_beat_num          (i_beat_num),
        .i_lut_dat           (i_lut_dat),
        .i_lut_vld           (i_lut_vld),
        .o_lut_rdy           (o_lut_rdy),
        .o_lut_bramctl_wdata (o_lut_bramctl_wdata),
        .o_lut_bramctl_addr  (o_lut_bramctl_addr),
        .o_lut_bramctl_we    (o_lut_bramctl_we),
        .o_lut_bramctl_en    (o_lut_bramctl_en),
        .i_in_vld            (i_in_vld),
        .i_out_vld           (i_out_vld),
        .o_calc_en           (o_calc_en),
        .o_calculate_end     (o_calculate_end),
        .o_busy              (o_busy),
        .o_done              (o_done),
        .o_err               (o_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_layer(input logic [1:0] act, input logic reload, input logic [15:0] beats);
        i_mode       = CONV;
        i_xpe_mode   = act;
        i_lut_reload = reload;
        i_beat_num   = beats;
        i_start      = 1'b1;
        step();
        i_start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int found;
        found = 0;
        for (int k = 0; k < budget; k++) begin
            step();
            if (o_done) begin
                found = 1;
                break;
            end
        end
        check_eq(tag, found, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cen, cend_n, cend_t, done_n, done_t;
        int sent, nwr, err_k, done_k;
        logic hs;

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_rdy", o_lut_rdy, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
        check_eq("rst_calc_en", o_calc_en, 0);
        check_eq("rst_done_err", {o_done, o_err, o_lut_bramctl_we}, 0);

        // 1: RELU layer, 4 beats, outputs 3 cycles after each input
        start_layer(RELU, 1'b0, 16'd4);
        check_eq("t1_busy", o_busy, 1);
        cen = int'(o_calc_en);
        cend_n = 0; cend_t = -1; done_n = 0; done_t = -1;
        for (int t = 0; t < 12; t++) begin
            i_in_vld  = (t < 4);
            i_out_vld = (t >= 3) && (t <= 6);
            step();
            cen += int'(o_calc_en);
            if (o_calculate_end) begin cend_n++; cend_t = t; end
            if (o_done) begin done_n++; done_t = t; end
        end
        i_in_vld  = 1'b0;
        i_out_vld = 1'b0;
        check_eq("t1_calc_en_cycles", cen, 4);
        check_eq("t1_calc_end_cycle", cend_t, 3);
        check_eq("t1_calc_end_count", cend_n, 1);
        check_eq("t1_done_cycle", done_t, 8);
        check_eq("t1_done_count", done_n, 1);
        check_eq("t1_err", o_err, 0);
        check_eq("t1_busy_end", o_busy, 0);

        // 2: SIGMOID with LUT reload, entries with valid gaps
        start_layer(SIGMOID, 1'b1, 16'd1);
        check_eq("t2_rdy", o_lut_rdy, 1);
        check_eq("t2_calc_en_load", o_calc_en, 0);
        sent = 0;
        nwr  = 0;
        for (int cyc = 0; cyc < 60 && nwr < 16; cyc++) begin
            i_lut_vld = (sent < 16) && (cyc % 3 != 1);
            i_lut_dat = 24'(sent + 1);
            hs = i_lut_vld && o_lut_rdy;
            step();
            if (hs) sent++;
            if (o_lut_bramctl_we) begin
                check_eq($sformatf("t2_addr%0d", nwr), o_lut_bramctl_addr, nwr);
                check_eq($sformatf("t2_wdata%0d", nwr), o_lut_bramctl_wdata, nwr + 1);
                check_eq($sformatf("t2_en%0d", nwr), o_lut_bramctl_en, 1);
                if (nwr == 15) begin
                    check_eq("t2_calc_en_on_last", o_calc_en, 1);
                    check_eq("t2_rdy_drop", o_lut_rdy, 0);
                end
                nwr++;
            end
        end
        i_lut_vld = 1'b0;
        check_eq("t2_writes", nwr, 16);
        i_in_vld  = 1'b1;
        i_out_vld = 1'b1;
        step();
        i_in_vld  = 1'b0;
        i_out_vld = 1'b0;
        check_eq("t2_calc_end", o_calculate_end, 1);
        wait_done("t2_done", 8);
        check_eq("t2_err", o_err, 0);
        step();

        // 3: zero-beat layer
        start_layer(RELU, 1'b0, 16'd0);
        check_eq("t3_calc_end", o_calculate_end, 1);
        check_eq("t3_calc_en", o_calc_en, 0);
        check_eq("t3_busy1", o_busy, 1);
        step();
        check_eq("t3_done", o_done, 1);
        check_eq("t3_busy2", o_busy, 1);
        check_eq("t3_calc_end_off", o_calculate_end, 0);
        step();
        check_eq("t3_busy3", o_busy, 0);

        // 4: 3 beats but only 2 outputs -> drain timeout
        start_layer(NOACT, 1'b0, 16'd3);
        i_in_vld = 1'b1;
        repeat (3) step();
        i_in_vld = 1'b0;
        check_eq("t4_calc_end", o_calculate_end, 1);
        i_out_vld = 1'b1;
        repeat (2) step();
        i_out_vld = 1'b0;
        err_k = -1;
        done_k = -1;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (o_err && err_k < 0) err_k = k;
            if (o_done) begin done_k = k; break; end
        end
        check_eq("t4_err_cycle", err_k, 64);
        check_eq("t4_done_cycle", done_k, 65);
        check_eq("t4_err_sticky", o_err, 1);
        start_layer(RELU, 1'b0, 16'd0);
        check_eq("t4_err_cleared", o_err, 0);
        repeat (2) step();

        // 5: abort during LUT load at entry 7
        start_layer(TANH, 1'b1, 16'd2);
        i_lut_vld = 1'b1;
        for (int k = 0; k < 7; k++) begin
            i_lut_dat = 24'(k + 1);
            step();
        end
        i_lut_dat = 24'd8;
        i_abort   = 1'b1;
        step();
        i_abort   = 1'b0;
        i_lut_vld = 1'b0;
        check_eq("t5_rdy", o_lut_rdy, 0);
        check_eq("t5_busy", o_busy, 0);
        check_eq("t5_we", o_lut_bramctl_we, 0);
        done_n = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            done_n += int'(o_done);
        end
        check_eq("t5_no_done", done_n, 0);
        start_layer(TANH, 1'b1, 16'd2);
        check_eq("t5_rdy_again", o_lut_rdy, 1);
        i_lut_vld = 1'b1;
        i_lut_dat = 24'hAA;
        step();
        i_lut_vld = 1'b0;
        check_eq("t5_addr0", o_lut_bramctl_addr, 0);
        check_eq("t5_wdata0", o_lut_bramctl_wdata, 24'hAA);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        check_eq("t5_busy_abort2", o_busy, 0);

        // 6: spurious third output and ignored starts while busy
        start_layer(RELU, 1'b0, 16'd2);
        i_in_vld   = 1'b1;
        i_start    = 1'b1;
        i_beat_num = 16'd0;
        step();
        i_start    = 1'b0;
        i_beat_num = 16'd2;
        check_eq("t6_no_restart", o_calculate_end, 0);
        check_eq("t6_calc_en", o_calc_en, 1);
        step();
        i_in_vld = 1'b0;
        check_eq("t6_calc_end", o_calculate_end, 1);
        i_out_vld = 1'b1;
        i_start   = 1'b1;
        repeat (3) step();
        i_out_vld = 1'b0;
        i_start   = 1'b0;
        check_eq("t6_err", o_err, 1);
        step();
        check_eq("t6_done", o_done, 1);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        check_eq("t6_err_kept_abort", o_err, 1);

        // Asynchronous reset mid-run
        start_layer(RELU, 1'b0, 16'd4);
        check_eq("rst2_calc_en_before", o_calc_en, 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_eq("rst2_calc_en", o_calc_en, 0);
        check_eq("rst2_busy", o_busy, 0);
        check_eq("rst2_err", o_err, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
